// File: rtl/uart_rx_word.sv
// UART receive framer: samples each bit mid-period and packs four bytes into a 32-bit word.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits.
module uart_rx_word #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        uart_rx,
    output logic [31:0] word_out,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        frame_err,
    output logic        parity_err,
    output logic        overrun
);
    localparam int            CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state, state_nxt;
    logic          sync1, rx_s, rx_prev;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic [1:0]    byte_cnt;
    logic [31:0]   asm_word;
    logic          tick_half, tick_full, stop_smp, perr, ferr, byte_ok;

    // rx_prev trails rx_s so only a genuine 1->0 transition starts a frame
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1   <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= uart_rx;
            rx_s    <= sync1;
            rx_prev <= rx_s;
        end
    end

    assign tick_half = (cnt == HALF_M1);
    assign tick_full = (cnt == FULL_M1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        stop_smp  = 1'b0;
        case (state)
            IDLE:   if (rx_prev && !rx_s) state_nxt = START;
            START:  if (tick_half) state_nxt = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            DATA:   if (tick_full && bit_idx == 3'd7) state_nxt = PARITY;
            PARITY: if (tick_full) state_nxt = STOP;
`else
            DATA:   if (tick_full && bit_idx == 3'd7) state_nxt = STOP;
`endif
            STOP: begin
                if (tick_full) begin
                    stop_smp  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                            par_bit <= 1'b0;
        else if (state == PARITY && tick_full) par_bit <= rx_s;
    end
    assign perr = ^{shreg, par_bit};
`else
    assign perr = 1'b0;
`endif

    assign ferr    = ~rx_s;
    assign byte_ok = ~ferr & ~perr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_cnt   <= '0;
            asm_word   <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            // Counter restarts at every sample point, so it is always the phase within a bit
            if (state == IDLE || (state == START && tick_half) || (state != START && tick_full))
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);

            if (state == START) bit_idx <= '0;
            if (state == DATA && tick_full) begin
                shreg   <= {rx_s, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end

            frame_err  <= stop_smp & ferr;
            parity_err <= stop_smp & perr;
            overrun    <= 1'b0;

            if (word_valid && word_ready) word_valid <= 1'b0;

            if (stop_smp) begin
                if (!byte_ok) begin
                    byte_cnt <= '0;
                    asm_word <= '0;
                end else if (byte_cnt == 2'd3) begin
                    byte_cnt <= '0;
                    asm_word <= '0;
                    if (!word_valid || word_ready) begin
                        word_out   <= {asm_word[31:8], shreg};
                        word_valid <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                end else begin
                    case (byte_cnt)
                        2'd0:    asm_word[31:24] <= shreg;
                        2'd1:    asm_word[23:16] <= shreg;
                        default: asm_word[15:8]  <= shreg;
                    endcase
                    byte_cnt <= byte_cnt + 2'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_word.sv
// Bench for uart_rx_word: directed scenarios plus random frames, checked against an
// event-level model (expected pulses/loads with cycle stamps) built from byte queues.
module tb_uart_rx_word;
    localparam int CPB = 8;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
    localparam int NBITS  = 11;
`else
    localparam bit PAR_EN = 1'b0;
    localparam int NBITS  = 10;
`endif
    // sync (2) + edge detect (1) + half bit + start/data/(parity) bits, +1 registered output
    localparam int OFS = 3 + CPB / 2 + (NBITS - 1) * CPB;

    localparam int EV_FERR = 1, EV_PERR = 2, EV_OVR = 3, EV_LOAD = 4, EV_DROP = 5;

    typedef struct {
        int          kind;
        logic [31:0] data;
        int          cyc;
    } ev_t;

    logic        clk, reset, uart_rx, word_ready;
    logic [31:0] word_out;
    logic        word_valid, frame_err, parity_err, overrun;

    int   total = 0, bad = 0, cyc = 0;
    ev_t  ev_q[$], exp_q[$];
    logic [7:0] m_part[$];
    logic m_valid = 1'b0;

    uart_rx_word #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset), .uart_rx(uart_rx),
        .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
        .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Observed events, stamped with the cycle count just after the edge that produced them
    initial begin
        logic        pv;
        logic [31:0] pw;
        pv = 1'b0;
        pw = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                if (frame_err)  ev_q.push_back('{EV_FERR, 32'h0, cyc});
                if (parity_err) ev_q.push_back('{EV_PERR, 32'h0, cyc});
                if (overrun)    ev_q.push_back('{EV_OVR, 32'h0, cyc});
                if (word_valid && (!pv || word_ready)) ev_q.push_back('{EV_LOAD, word_out, cyc});
                if (pv && !word_valid) ev_q.push_back('{EV_DROP, 32'h0, cyc});
                if (pv && word_valid && !word_ready) chk("stable", word_out, pw);
            end
            pv = word_valid;
            pw = word_out;
        end
    end

    task automatic exp_push(input int kind, input logic [31:0] data, input int c);
        exp_q.push_back('{kind, data, c});
    endtask

    task automatic compare_events(input string sec);
        chk({sec, ".nev"}, ev_q.size(), exp_q.size());
        for (int i = 0; i < ev_q.size() && i < exp_q.size(); i++) begin
            chk({sec, ".kind"}, ev_q[i].kind, exp_q[i].kind);
            chk({sec, ".cyc"},  ev_q[i].cyc,  exp_q[i].cyc);
            chk({sec, ".data"}, ev_q[i].data, exp_q[i].data);
        end
        ev_q.delete();
        exp_q.delete();
    endtask

    // Word-level reference: accepted bytes queue up; 4 make a word; consumer state is m_valid
    task automatic model_frame(input logic [7:0] b, input logic stop_v, input logic pflip,
                               input int ts, input logic rdy);
        int          t;
        logic        bad_b;
        logic [31:0] w;
        t     = ts + OFS;
        bad_b = 1'b0;
        if (!stop_v) begin exp_push(EV_FERR, 0, t); bad_b = 1'b1; end
        if (PAR_EN && pflip) begin exp_push(EV_PERR, 0, t); bad_b = 1'b1; end
        if (bad_b) m_part.delete();
        else begin
            m_part.push_back(b);
            if (m_part.size() == 4) begin
                w = {m_part[0], m_part[1], m_part[2], m_part[3]};
                m_part.delete();
                if (m_valid && !rdy) exp_push(EV_OVR, 0, t);
                else begin
                    exp_push(EV_LOAD, w, t);
                    if (rdy) exp_push(EV_DROP, 0, t + 1);
                    m_valid = !rdy;
                end
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic pflip,
                              input logic raise, input int abort_c, output int ts);
        logic [10:0] bits;
        bits = PAR_EN ? {stop_v, (^b) ^ pflip, b, 1'b0} : {1'b1, stop_v, b, 1'b0};
        ts = 0;
        for (int c = 0; c < NBITS * CPB; c++) begin
            @(negedge clk);
            if (c == 0) ts = cyc;
            if (c == abort_c) begin
                reset   = 1'b0;
                uart_rx = 1'b1;
                break;
            end
            uart_rx = bits[c / CPB];
            if (raise && cyc == ts + OFS - 1) word_ready = 1'b1;
        end
    endtask

    task automatic xfer(input logic [7:0] b, input logic stop_v, input logic pflip, input logic raise);
        int ts;
        send_frame(b, stop_v, pflip, raise, -1, ts);
        model_frame(b, stop_v, pflip, ts, word_ready);
        if (!stop_v) begin
            @(negedge clk);
            uart_rx = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) xfer(w[31 - 8 * i -: 8], 1'b1, 1'b0, 1'b0);
    endtask

    task automatic set_ready(input logic r);
        @(negedge clk);
        if (r && !word_ready && m_valid) begin
            exp_push(EV_DROP, 0, cyc + 1);
            m_valid = 1'b0;
        end
        word_ready = r;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int          ts;
        logic [7:0]  rb;
        logic        rs, rp;
        reset = 1'b0; uart_rx = 1'b1; word_ready = 1'b0;
        idle(3);
        chk("rst.word",  word_out, 32'h0);
        chk("rst.valid", 32'(word_valid), 32'h0);
        chk("rst.ferr",  32'(frame_err), 32'h0);
        chk("rst.perr",  32'(parity_err), 32'h0);
        chk("rst.ovr",   32'(overrun), 32'h0);
        reset = 1'b1;
        idle(3);

        set_ready(1'b1);
        send_word(32'hDEADBEEF);
        idle(4);
        compare_events("dbef");

        @(negedge clk) uart_rx = 1'b0;
        idle(3);
        uart_rx = 1'b1;
        idle(20);
        xfer(8'h55, 1'b1, 1'b0, 1'b0);
        xfer(8'h66, 1'b1, 1'b0, 1'b0);
        xfer(8'h77, 1'b1, 1'b0, 1'b0);
        xfer(8'h88, 1'b1, 1'b0, 1'b0);
        idle(4);
        compare_events("glitch");
        chk("glitch.word", word_out, 32'h55667788);

        xfer(8'hA1, 1'b1, 1'b0, 1'b0);
        xfer(8'hB2, 1'b1, 1'b0, 1'b0);
        xfer(8'h12, 1'b0, 1'b0, 1'b0);
        send_word(32'h01020304);
        idle(4);
        compare_events("ferr");
        chk("ferr.word", word_out, 32'h01020304);

        set_ready(1'b0);
        send_word(32'h11223344);
        send_word(32'hAABBCCDD);
        idle(4);
        compare_events("ovr");
        chk("ovr.word", word_out, 32'h11223344);
        xfer(8'hCA, 1'b1, 1'b0, 1'b0);
        xfer(8'hFE, 1'b1, 1'b0, 1'b0);
        xfer(8'hF0, 1'b1, 1'b0, 1'b0);
        xfer(8'h0D, 1'b1, 1'b0, 1'b1);
        idle(4);
        compare_events("raise");
        chk("raise.word", word_out, 32'hCAFEF00D);

        set_ready(1'b0);
        send_word(32'h99887766);
        xfer(8'h21, 1'b1, 1'b0, 1'b0);
        send_frame(8'h42, 1'b1, 1'b0, 1'b0, 5 * CPB + CPB / 2, ts);
        #1;
        chk("rmid.word",  word_out, 32'h0);
        chk("rmid.valid", 32'(word_valid), 32'h0);
        chk("rmid.ferr",  32'(frame_err), 32'h0);
        chk("rmid.perr",  32'(parity_err), 32'h0);
        chk("rmid.ovr",   32'(overrun), 32'h0);
        compare_events("prerst");
        m_part.delete();
        m_valid = 1'b0;
        idle(3);
        reset = 1'b1;
        idle(3);
        set_ready(1'b1);
        send_word(32'h0A0B0C0D);
        idle(4);
        compare_events("postrst");
        chk("postrst.word", word_out, 32'h0A0B0C0D);

`ifdef UART_RX_PARITY_EN
        xfer(8'h5A, 1'b1, 1'b0, 1'b0);
        xfer(8'h03, 1'b1, 1'b1, 1'b0);
        xfer(8'h03, 1'b1, 1'b0, 1'b0);
        xfer(8'h07, 1'b1, 1'b0, 1'b0);
        xfer(8'h00, 1'b1, 1'b0, 1'b0);
        xfer(8'hFF, 1'b1, 1'b0, 1'b0);
        idle(4);
        compare_events("par");
        chk("par.word", word_out, 32'h030700FF);
`endif

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) set_ready(1'($urandom_range(0, 1)));
            rb = 8'($urandom);
            rs = ($urandom_range(0, 7) != 0);
            rp = ($urandom_range(0, 7) == 0);
            xfer(rb, rs, rp, 1'b0);
            idle($urandom_range(0, 3));
        end
        idle(8);
        compare_events("rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_word.md
# uart_rx_word

Receive front-end for the UART link. It takes the raw `uart_rx` pin, synchronises and deserialises 8-bit frames using mid-bit sampling from a divided clock count, and packs four bytes into one 32-bit word. The word is handed to the word-level consumer over a valid/ready handshake. The block replaces ad-hoc pin sampling with a proper start/data/stop framer and reports framing, parity and overrun errors.

## Interface
- `CLKS_PER_BIT`, 434: clock cycles per UART bit (50 MHz / 115200); legal range ≥ 4.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `uart_rx`  in  1  asynchronous serial input; idle high.
- `word_out`  out  32  assembled word; first received byte in [31:24]; reset 0.
- `word_valid`  out  1  `word_out` holds an unconsumed word; reset 0.
- `word_ready`  in  1  consumer accepts `word_out` when high together with `word_valid`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low; reset 0.
- `parity_err`  out  1  one-cycle pulse: parity mismatch; reset 0; constant 0 without `UART_RX_PARITY_EN`.
- `overrun`  out  1  one-cycle pulse: completed word dropped because `word_valid` was still high; reset 0.

## Operation
- `uart_rx` passes through a 2-flop synchroniser (both flops reset to 1); all logic uses `rx_s`, the synchroniser output.
- Byte FSM: IDLE, START, DATA, PARITY (macro only), STOP.
- IDLE: a falling edge of `rx_s` goes to START and clears the bit-timing counter. A line held low never retriggers.
- START: wait CLKS_PER_BIT/2 cycles (integer division), then sample. If `rx_s`=1 the start was false: return to IDLE with no outputs changed. If `rx_s`=0, go to DATA.
- DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first, into a shift register. After bit 7, go to PARITY or STOP.
- STOP: sample once after CLKS_PER_BIT cycles, then return to IDLE.
  - Stop=1 with no parity error: the byte is accepted.
  - Stop=0: pulse `frame_err`, discard the byte, and clear the partial word.
- Word assembly: a byte counter runs 0..3. Accepted byte n is written to bits [31-8n:24-8n] of the assembly register.
- On acceptance of byte 3, the counter wraps to 0 and the word transfers to `word_out`:
  - If `word_valid`=0, load `word_out` and set `word_valid`.
  - If `word_valid`=1 and `word_ready`=1 in the same cycle, the handshake completes, the new word loads, and `word_valid` stays 1. No overrun.
  - If `word_valid`=1 and `word_ready`=0, keep the old word, drop the new one, and pulse `overrun`.
- `word_valid` clears on the cycle after `word_valid && word_ready`, unless a new word loads in that same cycle.
- `word_out` is stable while `word_valid`=1.
- Frame and parity errors both reset the byte counter to 0, which resynchronises word boundaries.
- Asserting `reset` at any time, including mid-byte, immediately returns the FSM to IDLE, clears all counters, the assembly register and all outputs, and sets the synchroniser flops to 1.

## Timing
- Let t0 be the first cycle `rx_s`=0 in IDLE. Input-to-`rx_s` latency is 2 cycles.
- Start sample is at t0+CLKS_PER_BIT/2.
- Data bit k (0..7) is sampled at t0+CLKS_PER_BIT/2+(k+1)·CLKS_PER_BIT.
- Parity is sampled at +9·CLKS_PER_BIT.
- Stop is sampled at +9·CLKS_PER_BIT without parity, +10·CLKS_PER_BIT with parity.
- `word_valid` rises, `word_out` updates, and `frame_err`/`parity_err`/`overrun` pulse exactly 1 cycle after the stop sample.
- A new falling edge is recognised from the cycle after the stop sample. Back-to-back frames with a 1-bit stop are supported.
- Throughput: one word per 4 frames. `word_ready` may be held high permanently.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - An even-parity bit follows bit 7 and is sampled in PARITY.
  - Mismatch (XOR of 8 data bits and parity bit ≠ 0) pulses `parity_err` at the stop-sample +1 cycle, discards the byte and clears the partial word.
  - If both errors occur, `frame_err` and `parity_err` both pulse.
- Not defined: there is no PARITY state, the frame is 10 bits, and `parity_err` is tied to 0.

## Test plan
- CLKS_PER_BIT=8, bytes 0xDE,0xAD,0xBE,0xEF, `word_ready`=1 -> `word_out`=0xDEADBEEF, `word_valid` high one cycle after 4th stop sample, then low the next cycle.
- 3-cycle low glitch on `uart_rx` while idle -> FSM returns to IDLE; no outputs change; a following byte 0x55 is received correctly.
- Byte 0x12 with stop bit forced 0 after two good bytes -> one-cycle `frame_err`; next four bytes 0x01,0x02,0x03,0x04 -> `word_out`=0x01020304.
- `word_ready`=0, two full words sent (0x11223344 then 0xAABBCCDD) -> `overrun` pulses once; `word_out` remains 0x11223344. Then raise `word_ready` on the exact cycle a third word 0xCAFEF00D completes -> `word_out`=0xCAFEF00D, `word_valid` stays 1, no `overrun`.
- Drive `reset` low in the middle of bit 4 of byte 2 -> all outputs 0 immediately. After release, a clean word 0x0A0B0C0D is received.
- With `UART_RX_PARITY_EN`: byte 0x03 sent with parity=1 -> `parity_err` pulse and partial word cleared. Bytes 0x03,0x07,0x00,0xFF with correct parity (0,1,0,0) -> `word_out`=0x030700FF.
